// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and defaults for the configurable UART
//               transmitter: FSM state encoding, data/length width defaults
//               and the minimum supported frame length.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int c_DATA_WD_DEF = 8;
    localparam int c_MIN_LEN     = 5;

    // Width needed to hold any data bit count 0..data_wd.
    function automatic int len_wd_for(input int data_wd);
        return $clog2(data_wd + 1);
    endfunction

    localparam int c_LEN_WD_DEF = len_wd_for(c_DATA_WD_DEF);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_par.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_par
// Description : Masked XOR parity. Only data bits below the effective length
//               contribute; odd parity is the inverted XOR.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_par
    import uart_pkg::*;
#(
    parameter int DATA_WD = c_DATA_WD_DEF,
    parameter int LEN_WD  = len_wd_for(DATA_WD)
) (
    input  logic [DATA_WD-1:0] i_data,
    input  logic [LEN_WD-1:0]  i_len,
    input  logic               i_par_typ,
    output logic               o_par_bit
);

    logic [DATA_WD-1:0] w_mask;

    // Bit i takes part in parity only when it is actually transmitted.
    for (genvar i = 0; i < DATA_WD; i++) begin : g_mask
        localparam logic [LEN_WD-1:0] c_IDX = LEN_WD'(i);
        assign w_mask[i] = (c_IDX < i_len);
    end

    assign o_par_bit = (^(i_data & w_mask)) ^ i_par_typ;

endmodule
`default_nettype wire

// File: rtl/uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_cfg
// Description : UART transmitter, one bit per clock, with runtime data
//               length (5..DATA_WD), optional even/odd parity and one or two
//               stop bits. A new frame may be accepted in the last stop-bit
//               cycle so back-to-back frames have no idle gap.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_WD = c_DATA_WD_DEF,
    parameter int LEN_WD  = len_wd_for(DATA_WD)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [DATA_WD-1:0] P_DATA,
    input  logic               DATA_VALID,
    input  logic [LEN_WD-1:0]  DATA_LEN,
    input  logic               PAR_EN,
    input  logic               PAR_TYP,
    input  logic               STP2,
    output logic               TX_OUT,
    output logic               Busy
);

    localparam logic [LEN_WD-1:0] c_MAX_LEN = LEN_WD'(DATA_WD);
    localparam logic [LEN_WD-1:0] c_MIN_LEN_W = LEN_WD'(c_MIN_LEN);
    localparam logic [LEN_WD-1:0] c_ONE     = LEN_WD'(1);
    localparam logic [LEN_WD-1:0] c_ZERO    = '0;

    tx_state_t          r_state;
    tx_state_t          w_state_nxt;
    logic               r_tx;
    logic               w_tx_nxt;
    logic               r_busy;
    logic [LEN_WD-1:0]  r_cnt;
    logic [LEN_WD-1:0]  w_cnt_nxt;
    logic [DATA_WD-1:0] r_shift;
    logic [DATA_WD-1:0] w_shift_nxt;

    // Shadow copy of the accepted frame configuration.
    logic [DATA_WD-1:0] r_data;
    logic [LEN_WD-1:0]  r_len;
    logic               r_par_en;
    logic               r_par_typ;
    logic               r_stp2;

    logic [LEN_WD-1:0]  w_len_eff;
    logic               w_last_stop;
    logic               w_last_data;
    logic               w_accept;
    logic               w_par_bit;

    // Out-of-range lengths fall back to the full data width.
    assign w_len_eff = ((DATA_LEN >= c_MIN_LEN_W) && (DATA_LEN <= c_MAX_LEN))
                       ? DATA_LEN : c_MAX_LEN;

    assign w_last_stop = (r_state == ST_STOP) && (!r_stp2 || (r_cnt == c_ONE));
    assign w_last_data = (r_cnt == (r_len - c_ONE));
    assign w_accept    = DATA_VALID && ((r_state == ST_IDLE) || w_last_stop);

    uart_tx_par #(
        .DATA_WD (DATA_WD),
        .LEN_WD  (LEN_WD)
    ) u_par (
        .i_data    (r_data),
        .i_len     (r_len),
        .i_par_typ (r_par_typ),
        .o_par_bit (w_par_bit)
    );

    // State, line and shadow registers; outputs are registered next values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= ST_IDLE;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_cnt     <= c_ZERO;
            r_shift   <= '0;
            r_data    <= '0;
            r_len     <= c_ZERO;
            r_par_en  <= 1'b0;
            r_par_typ <= 1'b0;
            r_stp2    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tx    <= w_tx_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
            if (w_accept) begin
                r_data    <= P_DATA;
                r_len     <= w_len_eff;
                r_par_en  <= PAR_EN;
                r_par_typ <= PAR_TYP;
                r_stp2    <= STP2;
            end
        end
    end

    // Next state and the bit to put on the line during that state.
    always_comb begin
        w_state_nxt = r_state;
        w_tx_nxt    = r_tx;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        case (r_state)
            ST_IDLE: begin
                w_tx_nxt = 1'b1;
                if (w_accept) begin
                    w_state_nxt = ST_START;
                    w_tx_nxt    = 1'b0;
                    w_cnt_nxt   = c_ZERO;
                    w_shift_nxt = P_DATA;
                end
            end
            ST_START: begin
                w_state_nxt = ST_DATA;
                w_tx_nxt    = r_shift[0];
                w_shift_nxt = r_shift >> 1;
                w_cnt_nxt   = c_ZERO;
            end
            ST_DATA: begin
                if (w_last_data) begin
                    w_cnt_nxt = c_ZERO;
                    if (r_par_en) begin
                        w_state_nxt = ST_PARITY;
                        w_tx_nxt    = w_par_bit;
                    end else begin
                        w_state_nxt = ST_STOP;
                        w_tx_nxt    = 1'b1;
                    end
                end else begin
                    w_cnt_nxt   = r_cnt + c_ONE;
                    w_tx_nxt    = r_shift[0];
                    w_shift_nxt = r_shift >> 1;
                end
            end
            ST_PARITY: begin
                w_state_nxt = ST_STOP;
                w_tx_nxt    = 1'b1;
                w_cnt_nxt   = c_ZERO;
            end
            ST_STOP: begin
                w_tx_nxt = 1'b1;
                if (w_last_stop) begin
                    w_cnt_nxt = c_ZERO;
                    if (w_accept) begin
                        w_state_nxt = ST_START;
                        w_tx_nxt    = 1'b0;
                        w_shift_nxt = P_DATA;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = c_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_tx_nxt    = 1'b1;
                w_cnt_nxt   = c_ZERO;
            end
        endcase
    end

    assign TX_OUT = r_tx;
    assign Busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_cfg
// Description : Scoreboard bench for uart_tx_cfg. Stimulus queues the
//               expected line bits and busy-run lengths; a monitor checks
//               them on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_cfg;

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic [3:0] DATA_LEN;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       STP2;
    logic       TX_OUT;
    logic       Busy;

    int n_cmp = 0;
    int n_err = 0;

    logic q_bit[$];
    int   q_run[$];

    uart_tx_cfg #(
        .DATA_WD (8),
        .LEN_WD  (4)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .DATA_LEN   (DATA_LEN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .STP2       (STP2),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bits are written left to right in transmit order.
    task automatic push_frame(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) q_bit.push_back(bits[i]);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (Busy !== 1'b0 && k < 200) begin
            @(posedge CLK);
            #1;
            k++;
        end
        if (k >= 200) begin
            n_cmp++;
            n_err++;
            $display("FAIL idle_timeout: busy=%b still high after %0d cycles", Busy, k);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic [3:0] len, input logic pe,
                        input logic pt, input logic s2, input logic [15:0] bits, input int n);
        wait_idle();
        push_frame(bits, n);
        q_run.push_back(n);
        P_DATA     = d;
        DATA_LEN   = len;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        STP2       = s2;
        DATA_VALID = 1'b1;
        @(posedge CLK);
        #1 DATA_VALID = 1'b0;
    endtask

    // Monitor: one expected bit per busy cycle, one run length per busy burst.
    initial begin : monitor
        int run;
        logic exp_bit;
        int exp_run;
        run = 0;
        forever begin
            @(negedge CLK);
            if (RST !== 1'b1) begin
                run = 0;
            end else if (Busy === 1'b1) begin
                run++;
                if (q_bit.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL tx_bit_unexpected: got busy=1 tx=%b required no frame", TX_OUT);
                end else begin
                    exp_bit = q_bit.pop_front();
                    check("tx_bit", 32'(TX_OUT), 32'(exp_bit));
                end
            end else begin
                check("idle_tx", 32'(TX_OUT), 32'd1);
                if (run > 0) begin
                    if (q_run.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL busy_run_unexpected: got run %0d required none", run);
                    end else begin
                        exp_run = q_run.pop_front();
                        check("busy_run", 32'(run), 32'(exp_run));
                    end
                    run = 0;
                end
            end
        end
    end

    initial begin : stimulus
        RST        = 1'b0;
        P_DATA     = 8'h00;
        DATA_VALID = 1'b0;
        DATA_LEN   = 4'd8;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        STP2       = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_tx", 32'(TX_OUT), 32'd1);
        check("reset_busy", 32'(Busy), 32'd0);
        RST = 1'b1;
        @(posedge CLK);
        #1;

        // 0xA5, 8 bits, no parity, 1 stop
        send(8'hA5, 4'd8, 1'b0, 1'b0, 1'b0, 16'b0101001011, 10);
        // 0x07, 8 bits, even parity -> 1
        send(8'h07, 4'd8, 1'b1, 1'b0, 1'b0, 16'b01110000011, 11);
        // 0xFF, 5 bits, odd parity -> 0, 2 stop
        send(8'hFF, 4'd5, 1'b1, 1'b1, 1'b1, 16'b011111011, 9);
        // 0xC3, 6 bits, even parity: upper bits excluded -> parity 0
        send(8'hC3, 4'd6, 1'b1, 1'b0, 1'b0, 16'b011000001, 9);
        // length 3 is out of range -> 8 bits
        send(8'h0F, 4'd3, 1'b0, 1'b0, 1'b0, 16'b0111100001, 10);
        // length 15 is out of range -> 8 bits, even parity -> 1
        send(8'h80, 4'd15, 1'b1, 1'b0, 1'b0, 16'b00000000111, 11);

        // Back-to-back with DATA_VALID held high
        wait_idle();
        push_frame(16'b0101010101, 10);
        push_frame(16'b0010101011, 10);
        q_run.push_back(20);
        P_DATA     = 8'h55;
        DATA_LEN   = 4'd8;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        STP2       = 1'b0;
        DATA_VALID = 1'b1;
        @(posedge CLK);
        #1 P_DATA = 8'hAA;
        repeat (10) @(posedge CLK);
        #1 DATA_VALID = 1'b0;

        // Mid-frame request must be ignored, shadow config unaffected
        send(8'hA5, 4'd8, 1'b1, 1'b1, 1'b1, 16'b010100101111, 12);
        repeat (3) @(posedge CLK);
        #1;
        P_DATA     = 8'h3C;
        DATA_LEN   = 4'd5;
        PAR_EN     = 1'b0;
        STP2       = 1'b0;
        DATA_VALID = 1'b1;
        @(posedge CLK);
        #1 DATA_VALID = 1'b0;

        // Reset during data bit 3 of 0x12 (bit 3 is 0)
        send(8'h12, 4'd8, 1'b0, 1'b0, 1'b0, 16'b0010010001, 10);
        repeat (4) @(posedge CLK);
        #1 RST = 1'b0;
        #1;
        check("midreset_tx", 32'(TX_OUT), 32'd1);
        check("midreset_busy", 32'(Busy), 32'd0);
        q_bit.delete();
        q_run.delete();
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
        @(posedge CLK);
        #1;
        check("post_reset_tx", 32'(TX_OUT), 32'd1);
        check("post_reset_busy", 32'(Busy), 32'd0);
        send(8'h81, 4'd8, 1'b0, 1'b0, 1'b0, 16'b0100000011, 10);

        wait_idle();
        repeat (3) @(posedge CLK);
        #1;
        check("bits_left", 32'(q_bit.size()), 32'd0);
        check("runs_left", 32'(q_run.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter DATA_WD, default 8, maximum data bits per frame (5..16).
REQ-002 SHALL have parameter LEN_WD, default $clog2(DATA_WD+1), width of DATA_LEN.
REQ-003 SHALL have CLK  input  1  single clock; all state on rising edge.
REQ-004 SHALL have RST  input  1  asynchronous, active-low reset.
REQ-005 SHALL have P_DATA  input  DATA_WD  parallel frame data, LSB sent first.
REQ-006 SHALL have DATA_VALID  input  1  request to send P_DATA.
REQ-007 SHALL have DATA_LEN  input  LEN_WD  runtime data bit count.
REQ-008 SHALL have PAR_EN  input  1  parity bit enable.
REQ-009 SHALL have PAR_TYP  input  1  0 = even, 1 = odd.
REQ-010 SHALL have STP2  input  1  0 = one stop bit, 1 = two stop bits.
REQ-011 SHALL have TX_OUT  output  1  serial line, registered, idle high.
REQ-012 SHALL have Busy  output  1  high while a frame is on the line, registered.

Function
REQ-013 SHALL implement FSM IDLE, START, DATA, PARITY, STOP; one bit per CLK cycle.
REQ-014 SHALL accept a frame only when DATA_VALID=1 and state is IDLE, or in the final stop-bit cycle.
- Accepting latches P_DATA, DATA_LEN, PAR_EN, PAR_TYP and STP2 into shadow registers.
REQ-015 SHALL ignore DATA_VALID in every other cycle; shadow registers are unchanged.
REQ-016 SHALL drive the start bit (TX_OUT=0) in the cycle after acceptance: one-cycle latency.
REQ-017 SHALL, in DATA, send shadow bits 0..L-1 LSB first, where L = effective length.
REQ-018 SHALL set L = DATA_LEN when 5 <= DATA_LEN <= DATA_WD; otherwise L = DATA_WD.
REQ-019 SHALL ignore P_DATA bits at index L and above for both shifting and parity.
REQ-020 SHALL compute parity over the L sent bits: even gives XOR; odd gives inverted XOR.
REQ-021 SHALL enter PARITY only when the latched PAR_EN=1; otherwise go DATA -> STOP.
REQ-022 SHALL drive TX_OUT=1 for 1 stop cycle (STP2=0) or 2 stop cycles (STP2=1).
REQ-023 SHALL make each frame last exactly 1+L+PAR_EN+1+STP2 cycles.
REQ-024 SHALL, on acceptance in the final stop cycle, go directly to START with no idle gap; Busy stays high.
REQ-025 SHALL assert Busy from the start-bit cycle through the last stop-bit cycle.
REQ-026 SHALL deassert Busy in the cycle after the last stop bit when no new frame was accepted.
REQ-027 SHALL use a bit counter of LEN_WD bits; it shall never wrap within a frame.

Reset
REQ-028 SHALL, when RST=0, force state IDLE, TX_OUT=1, Busy=0, counters 0 and shadow registers 0, asynchronously.
- This applies at any point, including mid-frame.
REQ-029 SHALL discard any partial frame on reset; the first DATA_VALID after RST deasserts starts a full new frame.

Structure
REQ-030 SHALL place the FSM state encoding and the DATA_WD/LEN_WD defaults in shared package uart_pkg.
REQ-031 SHALL instantiate one sub-module, uart_tx_par: a masked XOR parity calculator (data, L, PAR_TYP -> bit).
REQ-032 SHALL contain no latches and no derived clocks; baud timing comes from the supplied CLK.

Verification
REQ-033 SHALL cover: DATA_LEN=8, PAR_EN=0, STP2=0, P_DATA=0xA5 -> TX_OUT 0,1,0,1,0,0,1,0,1,1; Busy high 10 cycles.
REQ-034 SHALL cover: PAR_EN=1, PAR_TYP=0, P_DATA=0x07, L=8 -> parity bit 1; frame 11 cycles.
REQ-035 SHALL cover: DATA_LEN=5, PAR_EN=1, PAR_TYP=1, STP2=1, P_DATA=0xFF -> TX_OUT 0,1,1,1,1,1,0,1,1; 9 cycles.
REQ-036 SHALL cover: DATA_VALID held high, 0x55 then 0xAA -> second start bit in the cycle after the first stop bit; Busy never drops.
REQ-037 SHALL cover: DATA_VALID=1 with P_DATA=0x3C pulsed mid-frame -> ignored; the current frame and its bits are unchanged.
REQ-038 SHALL cover: RST=0 during data bit 3 -> TX_OUT=1 and Busy=0 immediately; then 0x81 after release -> complete, correct frame.
